// File: rtl/fp_add_seq_ctrl_if.sv
// Operand issue / result writeback bundle for the sequential FP adder controller.
// The slave side is the controller; the master side is the issuer and consumer.
interface fp_add_seq_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              sub;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              overflow;
    logic              busy;

    modport master (
        output in_valid, op_a, op_b, sub, out_ready,
        input  in_ready, out_valid, result, overflow, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, sub, out_ready,
        output in_ready, out_valid, result, overflow, busy
    );
endinterface

// File: rtl/fp_add_seq_ctrl.sv
// Multi-cycle IEEE-754 adder controller: capture, align, add, normalize one bit
// per cycle, then pack. Denormals flush to zero and rounding is truncation.
module fp_add_seq_ctrl #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                clk,
    input  logic                rst_n,
    fp_add_seq_ctrl_if.slave    bus
);
    localparam int W = 1 + EXP_W + FRAC_W;
    localparam int M = FRAC_W + 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ALIGN = 3'd1;
    localparam logic [2:0] ADD   = 3'd2;
    localparam logic [2:0] NORM  = 3'd3;
    localparam logic [2:0] PACK  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [EXP_W-1:0] SHIFT_LIM = EXP_W'(M);
    localparam logic [EXP_W:0]   EXP_ONE   = (EXP_W+1)'(1);
    localparam logic [EXP_W:0]   EXP_MAX   = {1'b0, {EXP_W{1'b1}}};

    logic [2:0]        state;
    logic              a_sign, b_sign;
    logic [EXP_W-1:0]  a_exp, b_exp;
    logic [FRAC_W-1:0] a_frac, b_frac;
    logic              special, eff_sub, sign_r, overflow_r;
    logic [EXP_W:0]    exp_r;
    logic [M-1:0]      ma_r, mb_r;
    logic [M:0]        sum_r;
    logic [W-1:0]      result_r;

    logic [EXP_W-1:0]  in_ea, in_eb;
    logic [FRAC_W-1:0] in_fa, in_fb;
    logic              in_sb, in_special;
    logic [W-1:0]      special_res;

    // Special-operand result chosen at capture; B already carries the sub inversion.
    always_comb begin
        in_ea       = bus.op_a[W-2 -: EXP_W];
        in_eb       = bus.op_b[W-2 -: EXP_W];
        in_fa       = bus.op_a[FRAC_W-1:0];
        in_fb       = bus.op_b[FRAC_W-1:0];
        in_sb       = bus.op_b[W-1] ^ bus.sub;
        in_special  = (&in_ea) || (&in_eb);
        special_res = bus.op_a;
        if ((&in_ea) && (|in_fa))
            special_res = bus.op_a;
        else if ((&in_eb) && (|in_fb))
            special_res = {in_sb, bus.op_b[W-2:0]};
        else if ((&in_ea) && (&in_eb) && (bus.op_a[W-1] != in_sb))
            special_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
        else if (&in_ea)
            special_res = bus.op_a;
        else
            special_res = {in_sb, bus.op_b[W-2:0]};
    end

    logic              swap, big_sign;
    logic [EXP_W-1:0]  big_exp, small_exp, diff;
    logic [M-1:0]      big_mant, small_mant, shifted;

    // Magnitude ordering and the right-shift alignment unit.
    always_comb begin
        swap       = {b_exp, b_frac} > {a_exp, a_frac};
        big_sign   = swap ? b_sign : a_sign;
        big_exp    = swap ? b_exp : a_exp;
        small_exp  = swap ? a_exp : b_exp;
        big_mant   = swap ? {|b_exp, b_frac} : {|a_exp, a_frac};
        small_mant = swap ? {|a_exp, a_frac} : {|b_exp, b_frac};
        diff       = big_exp - small_exp;
        shifted    = (diff >= SHIFT_LIM) ? '0 : (small_mant >> diff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sign     <= 1'b0;
            b_sign     <= 1'b0;
            a_exp      <= '0;
            b_exp      <= '0;
            a_frac     <= '0;
            b_frac     <= '0;
            special    <= 1'b0;
            eff_sub    <= 1'b0;
            sign_r     <= 1'b0;
            exp_r      <= '0;
            ma_r       <= '0;
            mb_r       <= '0;
            sum_r      <= '0;
            result_r   <= '0;
            overflow_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sign     <= bus.op_a[W-1];
                        b_sign     <= in_sb;
                        a_exp      <= in_ea;
                        b_exp      <= in_eb;
                        a_frac     <= (in_ea == '0) ? '0 : in_fa;
                        b_frac     <= (in_eb == '0) ? '0 : in_fb;
                        special    <= in_special;
                        result_r   <= special_res;
                        overflow_r <= 1'b0;
                        state      <= in_special ? PACK : ALIGN;
                    end
                end
                ALIGN: begin
                    sign_r  <= big_sign;
                    exp_r   <= {1'b0, big_exp};
                    ma_r    <= big_mant;
                    mb_r    <= shifted;
                    eff_sub <= a_sign ^ b_sign;
                    state   <= ADD;
                end
                ADD: begin
                    sum_r <= eff_sub ? ({1'b0, ma_r} - {1'b0, mb_r})
                                     : ({1'b0, ma_r} + {1'b0, mb_r});
                    state <= NORM;
                end
                // One normalization step per cycle; underflow on left shift flushes to +0.
                NORM: begin
                    if (sum_r == '0) begin
                        sign_r <= 1'b0;
                        exp_r  <= '0;
                        state  <= PACK;
                    end else if (sum_r[M]) begin
                        sum_r <= sum_r >> 1;
                        exp_r <= exp_r + EXP_ONE;
                        state <= PACK;
                    end else if (sum_r[M-1]) begin
                        state <= PACK;
                    end else if (exp_r <= EXP_ONE) begin
                        sign_r <= 1'b0;
                        exp_r  <= '0;
                        sum_r  <= '0;
                        state  <= PACK;
                    end else begin
                        sum_r <= sum_r << 1;
                        exp_r <= exp_r - EXP_ONE;
                    end
                end
                PACK: begin
                    if (!special) begin
                        if (exp_r >= EXP_MAX) begin
                            result_r   <= {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                            overflow_r <= 1'b1;
                        end else begin
                            result_r <= {sign_r, exp_r[EXP_W-1:0], sum_r[FRAC_W-1:0]};
                        end
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (bus.out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_r;
    assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_fp_add_seq_ctrl.sv
// Directed bench for fp_add_seq_ctrl with an arithmetic reference model and a
// per-cycle output compare against the queue of expected results.
module tb_fp_add_seq_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [31:0] exp_res_q[$];
    logic        exp_ovf_q[$];

    fp_add_seq_ctrl_if bus();

    fp_add_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic; cyc is the out_valid cycle with the accept cycle as 0.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] r, output logic ov, output int cyc);
        logic        sa, sb, sgn, tsg;
        logic [31:0] bc;
        int ea, eb, fa, fb, ma, mb, sum, e, k, n, t;
        sa = a[31];
        sb = b[31] ^ s;
        bc = {sb, b[30:0]};
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = int'(a[22:0]);
        fb = int'(b[22:0]);
        ov = 1'b0;
        if (ea == 255 || eb == 255) begin
            cyc = 2;
            if (ea == 255 && fa != 0)                   r = a;
            else if (eb == 255 && fb != 0)              r = bc;
            else if (ea == 255 && eb == 255 && sa != sb) r = 32'h7FC00000;
            else if (ea == 255)                         r = a;
            else                                        r = bc;
            return;
        end
        if (ea == 0) fa = 0;
        if (eb == 0) fb = 0;
        if (eb * (1 << 23) + fb > ea * (1 << 23) + fa) begin
            t = ea; ea = eb; eb = t;
            t = fa; fa = fb; fb = t;
            tsg = sa; sa = sb; sb = tsg;
        end
        ma  = (ea != 0) ? fa + (1 << 23) : 0;
        mb  = (eb != 0) ? fb + (1 << 23) : 0;
        mb  = (ea - eb >= 24) ? 0 : (mb >> (ea - eb));
        sum = (sa == sb) ? ma + mb : ma - mb;
        e   = ea;
        sgn = sa;
        if (sum == 0) begin
            n = 1;
            r = 32'h0;
        end else if (sum >= (1 << 24)) begin
            n   = 1;
            e   = e + 1;
            sum = sum / 2;
            r   = (e >= 255) ? {sgn, 8'hFF, 23'h0} : {sgn, 8'(e), 23'(sum)};
            ov  = (e >= 255);
        end else begin
            k = 0;
            while (k < 24 && (sum << k) < (1 << 23)) k++;
            if (e - k >= 1) begin
                n = k + 1;
                r = {sgn, 8'(e - k), 23'(sum << k)};
            end else begin
                n = e;
                r = 32'h0;
            end
        end
        cyc = 4 + n;
    endfunction

    // Every cycle the result is presented it must equal the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_res_q.size() == 0) begin
                checkOutput("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                checkOutput("result", bus.result, exp_res_q[0]);
                checkOutput("overflow", 32'(bus.overflow), 32'(exp_ovf_q[0]));
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 input bit noisy);
        logic [31:0] r;
        logic        ov;
        int          cyc;
        int          e;
        model(a, b, s, r, ov, cyc);
        @(negedge clk);
        checkOutput("in_ready_idle", 32'(bus.in_ready), 32'd1);
        checkOutput("busy_idle", 32'(bus.busy), 32'd0);
        exp_res_q.push_back(r);
        exp_ovf_q.push_back(ov);
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.sub      = s;
        @(posedge clk);
        #1;
        if (noisy) begin
            bus.op_a = 32'h4049_0FDB;
            bus.op_b = 32'hC2C8_0000;
            bus.sub  = ~s;
        end else begin
            bus.in_valid = 1'b0;
        end
        checkOutput("busy_after_accept", 32'(bus.busy), 32'd1);
        checkOutput("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
        e = 0;
        while (!bus.out_valid && e < 200) begin
            @(posedge clk);
            #1;
            e++;
        end
        bus.in_valid = 1'b0;
        if (!bus.out_valid)
            checkOutput("out_valid_timeout", 32'd0, 32'd1);
        else
            checkOutput("latency", 32'(e + 1), 32'(cyc));
    endtask

    task automatic holdOutput(input int hold);
        repeat (hold) begin
            @(negedge clk);
            checkOutput("in_ready_held", 32'(bus.in_ready), 32'd0);
            checkOutput("out_valid_held", 32'(bus.out_valid), 32'd1);
        end
    endtask

    task automatic finishOp(input int hold);
        holdOutput(hold);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        void'(exp_res_q.pop_front());
        void'(exp_ovf_q.pop_front());
        checkOutput("out_valid_drop", 32'(bus.out_valid), 32'd0);
        checkOutput("in_ready_return", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic checkModel(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic s, input logic [31:0] r_req, input logic ov_req,
                              input int cyc_req);
        logic [31:0] r;
        logic        ov;
        int          cyc;
        model(a, b, s, r, ov, cyc);
        checkOutput({name, "_res"}, r, r_req);
        checkOutput({name, "_ovf"}, 32'(ov), 32'(ov_req));
        checkOutput({name, "_cyc"}, 32'(cyc), 32'(cyc_req));
    endtask

    logic [31:0] va[12] = '{32'h3F800000, 32'h3F800000, 32'h4B800000, 32'h7F7FFFFF,
                            32'h7F800000, 32'h3F800001, 32'h40400000, 32'h3FC00000,
                            32'h7FC00001, 32'h00000001, 32'h80000000, 32'h3F800000};
    logic [31:0] vb[12] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F7FFFFF,
                            32'hFF800000, 32'h3F800000, 32'hBF800000, 32'h40100000,
                            32'h3F800000, 32'h3F800000, 32'h80000000, 32'h40000000};
    logic        vs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_result", bus.result, 32'h0);
        checkOutput("reset_overflow", 32'(bus.overflow), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        checkModel("m_one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 5);
        checkModel("m_one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 5);
        checkModel("m_diff24", 32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 1'b0, 5);
        checkModel("m_overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 5);
        checkModel("m_inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 2);
        checkModel("m_long_norm", 32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 1'b0, 28);
        checkModel("m_neg_result", 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 6);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(va[i], vb[i], vs[i], (i % 4) == 1);
            finishOp(i % 3);
        end

        // Backpressure followed by an asynchronous reset while the result is held.
        applyStimulus(32'h3F800000, 32'h40000000, 1'b0, 1'b0);
        holdOutput(10);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_result", bus.result, 32'h0);
        exp_res_q.delete();
        exp_ovf_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'h40400000, 32'h3F800000, 1'b1, 1'b0);
        finishOp(1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
